addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_if.sv | 36 +++
 rtl/addsub_arbiter.sv | 118 +++++++++++
 tb/tb_addsub_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - request/response bundle for the two-requester add/sub arbiter
// rsp_carry exists only when ADDSUB_ARBITER_CARRY_EN is defined.
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_data;
`ifdef ADDSUB_ARBITER_CARRY_EN
    logic               rsp_carry;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
`endif
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one registered add/sub unit between two requesters
// Define ADDSUB_ARBITER_CARRY_EN to add the registered rsp_carry carry/borrow output.
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    addsub_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic             grant;
    logic [1:0]       ready;
    logic             accept;

`ifdef ADDSUB_ARBITER_CARRY_EN
    logic [WIDTH:0]   result;
    logic             carry_q, carry_d;

    // Zero-extended subtract leaves the borrow (A < B) in the top bit, same as add's carry-out.
    assign result = op_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    assign bus.rsp_carry = carry_q;
`else
    logic [WIDTH-1:0] result;

    assign result = op_q ? (a_q - b_q) : (a_q + b_q);
`endif

    always_comb begin
        grant = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
        ready = 2'b00;
        if (state_q == IDLE && !rst && bus.req_valid != 2'b00)
            ready = grant ? 2'b10 : 2'b01;
        accept = |(bus.req_valid & ready);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
`ifdef ADDSUB_ARBITER_CARRY_EN
        carry_d      = carry_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = grant;
                    id_d         = grant;
                    a_d          = grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                    b_d          = grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                    op_d         = bus.req_op[grant];
                end
            end
            EXEC: begin
                state_d    = RESP;
                rsp_data_d = result[WIDTH-1:0];
                rsp_id_d   = id_q;
`ifdef ADDSUB_ARBITER_CARRY_EN
                carry_d    = result[WIDTH];
`endif
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
`ifdef ADDSUB_ARBITER_CARRY_EN
            carry_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
`ifdef ADDSUB_ARBITER_CARRY_EN
            carry_q      <= carry_d;
`endif
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench for addsub_arbiter against a behavioural arithmetic model
module tb_addsub_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   m_last;
    logic [W-1:0] opa [2];
    logic [W-1:0] opb [2];
    logic         opo [2];

    addsub_arbiter_if #(.WIDTH(W)) bus ();

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_data(input int a, input int b, input int op);
        return op ? ((a - b + 16) % 16) : ((a + b) % 16);
    endfunction

    function automatic int exp_carry(input int a, input int b, input int op);
        return op ? int'(a < b) : int'(a + b > 15);
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
            opo[i] = 1'($urandom);
        end
        bus.req_a  = {opa[1], opa[0]};
        bus.req_b  = {opb[1], opb[0]};
        bus.req_op = {opo[1], opo[0]};
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        bus.req_a     = '1;
        bus.req_b     = '1;
        bus.req_op    = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 4'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); end
`ifdef ADDSUB_ARBITER_CARRY_EN
        checks++; if (bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_rsp_carry: got %b expected 0", bus.rsp_carry); end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req_valid = 2'b00;
        m_last = 1;
    endtask

    task automatic test_basic();
        bus.req_valid = 2'b01;
        bus.req_a     = {4'd0, 4'd3};
        bus.req_b     = {4'd0, 4'd5};
        bus.req_op    = 2'b00;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL basic_req_ready: got %b expected 01", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        m_last = 0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 4'd8) begin errors++; $display("FAIL basic_rsp_data: got %h expected 8", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL basic_rsp_id: got %b expected 0", bus.rsp_id); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alternate();
        int g;
        apply_reset();
        rand_ops();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = 1 - m_last;
            m_last = g;
            @(negedge clk);
            checks++; if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_grant[%0d]: got %b expected requester %0d", k, bus.req_ready, g); end
            @(negedge clk);
            checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL alt_exec[%0d]: got ready=%b valid=%b expected 00/0", k, bus.req_ready, bus.rsp_valid); end
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(g)) begin errors++; $display("FAIL alt_rsp[%0d]: got valid=%b id=%b expected 1/%0d", k, bus.rsp_valid, bus.rsp_id, g); end
            checks++; if (int'(bus.rsp_data) != exp_data(opa[g], opb[g], opo[g])) begin errors++; $display("FAIL alt_data[%0d]: got %h expected %h", k, bus.rsp_data, exp_data(opa[g], opb[g], opo[g])); end
        end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
    endtask

    task automatic test_carry();
        int ta [2] = '{2, 15};
        int tb [2] = '{5, 1};
        int td [2] = '{13, 0};
        int g;
        for (int k = 0; k < 2; k++) begin
            g = 1 - k;
            opa[g] = W'(ta[k]); opb[g] = W'(tb[k]); opo[g] = (k == 0);
            opa[1-g] = '0; opb[1-g] = '0; opo[1-g] = 1'b0;
            bus.req_a  = {opa[1], opa[0]};
            bus.req_b  = {opb[1], opb[0]};
            bus.req_op = {opo[1], opo[0]};
            bus.req_valid = g ? 2'b10 : 2'b01;
            bus.rsp_ready = 1'b1;
            m_last = g;
            @(posedge clk);
            #1 bus.req_valid = 2'b00;
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_data) != td[k]) begin errors++; $display("FAIL carry_data[%0d]: got valid=%b data=%h expected 1/%h", k, bus.rsp_valid, bus.rsp_data, td[k]); end
`ifdef ADDSUB_ARBITER_CARRY_EN
            checks++; if (bus.rsp_carry !== 1'b1) begin errors++; $display("FAIL carry_flag[%0d]: got %b expected 1", k, bus.rsp_carry); end
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        int g;
        rand_ops();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b11;
        g = 1 - m_last;
        m_last = g;
        @(negedge clk);
        checks++; if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL stall_grant: got %b expected requester %0d", bus.req_ready, g); end
        @(posedge clk);
        @(posedge clk);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(g) || bus.req_ready !== 2'b00) begin errors++; $display("FAIL stall_hold[%0d]: got valid=%b id=%b ready=%b expected 1/%0d/00", s, bus.rsp_valid, bus.rsp_id, bus.req_ready, g); end
            checks++; if (int'(bus.rsp_data) != exp_data(opa[g], opb[g], opo[g])) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", s, bus.rsp_data, exp_data(opa[g], opb[g], opo[g])); end
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got ready=%b valid=%b expected 00/1", bus.req_ready, bus.rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== ((1 - g) ? 2'b10 : 2'b01) || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_next_grant: got ready=%b valid=%b expected requester %0d/0", bus.req_ready, bus.rsp_valid, 1 - g); end
        #1 bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        rand_ops();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b01;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rmid_grant: got %b expected 01", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 2'b11;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 4'h0 || bus.rsp_id !== 1'b0 || bus.req_ready !== 2'b00) begin errors++; $display("FAIL rmid_outputs: got valid=%b data=%h id=%b ready=%b expected 0/0/0/00", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready); end
`ifdef ADDSUB_ARBITER_CARRY_EN
        checks++; if (bus.rsp_carry !== 1'b0) begin errors++; $display("FAIL rmid_carry: got %b expected 0", bus.rsp_carry); end
`endif
        m_last = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp[%0d]: got %b expected 0", c, bus.rsp_valid); end
        end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rmid_first_grant: got %b expected 01", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        m_last = 0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_exec: got %b expected 0", bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || int'(bus.rsp_data) != exp_data(opa[0], opb[0], opo[0])) begin errors++; $display("FAIL rmid_rsp: got valid=%b id=%b data=%h expected 1/0/%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_data(opa[0], opb[0], opo[0])); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [1:0] v;
        int g, ea, eb, eo, stall;
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            v = 2'($urandom_range(1, 3));
            stall = $urandom_range(0, 2);
            bus.req_valid = v;
            bus.rsp_ready = 1'b0;
            g = (v == 2'b11) ? 1 - m_last : int'(v[1]);
            m_last = g;
            ea = opa[g]; eb = opb[g]; eo = opo[g];
            @(negedge clk);
            checks++; if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_grant[%0d]: got %b expected requester %0d", n, bus.req_ready, g); end
            @(posedge clk);
            #1 rand_ops();
            bus.req_valid = 2'($urandom);
            @(negedge clk);
            checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_exec[%0d]: got ready=%b valid=%b expected 00/0", n, bus.req_ready, bus.rsp_valid); end
            @(posedge clk);
            for (int s = 0; s <= stall; s++) begin
                #1 if (s == stall) bus.rsp_ready = 1'b1;
                @(negedge clk);
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(g) || int'(bus.rsp_data) != exp_data(ea, eb, eo)) begin errors++; $display("FAIL rand_rsp[%0d]: got valid=%b id=%b data=%h expected 1/%0d/%h", n, bus.rsp_valid, bus.rsp_id, bus.rsp_data, g, exp_data(ea, eb, eo)); end
`ifdef ADDSUB_ARBITER_CARRY_EN
                checks++; if (int'(bus.rsp_carry) != exp_carry(ea, eb, eo)) begin errors++; $display("FAIL rand_carry[%0d]: got %b expected %0d", n, bus.rsp_carry, exp_carry(ea, eb, eo)); end
`endif
                @(posedge clk);
            end
            #1 bus.req_valid = 2'b00;
            bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_carry();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
